// File: rtl/i2c_pkg.sv
`default_nettype none
// ============================================================================
// Module      : i2c_pkg
// Description : Shared state encoding and constants for the I2C target receiver.
// Revision    : 1.0 - initial release
// ============================================================================
package i2c_pkg;

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] ADDR     = 3'd1;
    localparam logic [2:0] ADDR_ACK = 3'd2;
    localparam logic [2:0] DATA     = 3'd3;
    localparam logic [2:0] DATA_ACK = 3'd4;
    localparam logic [2:0] IGNORE   = 3'd5;

    localparam logic RW_WRITE  = 1'b0;
    localparam int   BYTE_BITS = 8;

endpackage
`default_nettype wire

// File: rtl/i2c_line_sync.sv
`default_nettype none
// ============================================================================
// Module      : i2c_line_sync
// Description : Multi-flop synchronizer with one-cycle rise/fall detection.
//               Presets to 1 so an idle (pulled-up) bus shows no edge at reset.
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_line_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic mclk,
    input  logic rst,
    input  logic i_line,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    always_ff @(posedge mclk or negedge rst) begin
        if (!rst) begin
            r_sync <= '1;
            r_prev <= 1'b1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_line};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_level = r_sync[SYNC_STAGES-1];
    assign o_rise  =  r_sync[SYNC_STAGES-1] & ~r_prev;
    assign o_fall  = ~r_sync[SYNC_STAGES-1] &  r_prev;

endmodule
`default_nettype wire

// File: rtl/i2c_target_rx.sv
`default_nettype none
// ============================================================================
// Module      : i2c_target_rx
// Description : I2C target write receiver: START/STOP detect, address match
//               with ACK, data bytes presented with a one-cycle valid strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_target_rx #(
    parameter logic [6:0] TGT_ADDR    = 7'h2A,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       mclk,
    input  logic       rst,
    input  logic       iSCL,
    input  logic       iSDA,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       addr_hit,
    output logic       busy,
    output logic       start_det,
    output logic       stop_det
);

    import i2c_pkg::*;

    localparam logic [3:0] c_BYTE_CNT = 4'(BYTE_BITS);
    localparam logic [3:0] c_LAST_BIT = 4'(BYTE_BITS - 1);

    logic w_scl, w_scl_rise, w_scl_fall;
    logic w_sda, w_sda_rise, w_sda_fall;
    logic w_start, w_stop, w_addr_match;

    logic [2:0] r_state;
    logic [3:0] r_cnt;
    logic [7:0] r_shift;
    logic       r_load;

    i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_scl_sync (
        .mclk    (mclk),
        .rst     (rst),
        .i_line  (iSCL),
        .o_level (w_scl),
        .o_rise  (w_scl_rise),
        .o_fall  (w_scl_fall)
    );

    i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sda_sync (
        .mclk    (mclk),
        .rst     (rst),
        .i_line  (iSDA),
        .o_level (w_sda),
        .o_rise  (w_sda_rise),
        .o_fall  (w_sda_fall)
    );

    assign w_start      = w_sda_fall & w_scl;
    assign w_stop       = w_sda_rise & w_scl;
    assign w_addr_match = (r_shift[7:1] == TGT_ADDR) && (r_shift[0] == RW_WRITE);

    always_ff @(posedge mclk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_cnt     <= 4'd0;
            r_shift   <= 8'h00;
            r_load    <= 1'b0;
            sda_oe    <= 1'b0;
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
            addr_hit  <= 1'b0;
            busy      <= 1'b0;
            start_det <= 1'b0;
            stop_det  <= 1'b0;
        end else begin
            start_det <= 1'b0;
            stop_det  <= 1'b0;
            rx_valid  <= 1'b0;
            r_load    <= 1'b0;

            // Byte is published one cycle after its last bit lands in r_shift.
            if (r_load) begin
                rx_data  <= r_shift;
                rx_valid <= 1'b1;
            end

            if (w_start) begin
                r_state   <= ADDR;
                r_cnt     <= 4'd0;
                addr_hit  <= 1'b0;
                sda_oe    <= 1'b0;
                busy      <= 1'b1;
                start_det <= 1'b1;
            end else if (w_stop) begin
                r_state  <= IDLE;
                busy     <= 1'b0;
                addr_hit <= 1'b0;
                sda_oe   <= 1'b0;
                stop_det <= 1'b1;
            end else begin
                case (r_state)
                    ADDR: begin
                        if (r_cnt == c_BYTE_CNT) begin
                            if (!w_addr_match) begin
                                r_state <= IGNORE;
                            end else if (w_scl_fall) begin
                                sda_oe  <= 1'b1;
                                r_state <= ADDR_ACK;
                            end
                        end else if (w_scl_rise) begin
                            r_shift <= {r_shift[6:0], w_sda};
                            r_cnt   <= r_cnt + 4'd1;
                        end
                    end
                    ADDR_ACK: begin
                        if (w_scl_fall) begin
                            sda_oe   <= 1'b0;
                            addr_hit <= 1'b1;
                            r_cnt    <= 4'd0;
                            r_state  <= DATA;
                        end
                    end
                    DATA: begin
                        if (r_cnt == c_BYTE_CNT) begin
                            if (w_scl_fall) begin
                                sda_oe  <= 1'b1;
                                r_state <= DATA_ACK;
                            end
                        end else if (w_scl_rise) begin
                            r_shift <= {r_shift[6:0], w_sda};
                            r_cnt   <= r_cnt + 4'd1;
                            r_load  <= (r_cnt == c_LAST_BIT);
                        end
                    end
                    DATA_ACK: begin
                        if (w_scl_fall) begin
                            sda_oe  <= 1'b0;
                            r_cnt   <= 4'd0;
                            r_state <= DATA;
                        end
                    end
                    default: begin
                        sda_oe <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_i2c_target_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_i2c_target_rx
// Description : Directed open-drain bus master (SCL = mclk/16) against the
//               I2C target receiver, with hand-computed expected values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_target_rx;

    import i2c_pkg::*;

    logic       r_mclk = 1'b0;
    logic       r_rst  = 1'b0;
    logic       r_scl  = 1'b1;
    logic       r_sda  = 1'b1;
    logic       w_sda_line;
    logic       sda_oe, rx_valid, addr_hit, busy, start_det, stop_det;
    logic [7:0] rx_data;

    int         n_tests = 0;
    int         n_fail  = 0;
    int         rx_cnt, st_cnt, sp_cnt;
    logic       oe_seen, hit_seen;
    logic [7:0] rxq[$];
    logic       ack_n, ack_oe, l_dummy, o_dummy;

    assign w_sda_line = r_sda & ~sda_oe;

    always #5 r_mclk = ~r_mclk;

    i2c_target_rx #(.TGT_ADDR(7'h2A), .SYNC_STAGES(2)) dut (
        .mclk      (r_mclk),
        .rst       (r_rst),
        .iSCL      (r_scl),
        .iSDA      (w_sda_line),
        .sda_oe    (sda_oe),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .addr_hit  (addr_hit),
        .busy      (busy),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    always @(negedge r_mclk) begin
        if (rx_valid) begin
            rx_cnt++;
            rxq.push_back(rx_data);
        end
        if (start_det) st_cnt++;
        if (stop_det)  sp_cnt++;
        if (sda_oe)    oe_seen  = 1'b1;
        if (addr_hit)  hit_seen = 1'b1;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, exp %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge r_mclk);
    endtask

    task automatic clr_mon();
        rx_cnt = 0; st_cnt = 0; sp_cnt = 0;
        oe_seen = 1'b0; hit_seen = 1'b0;
        rxq.delete();
    endtask

    task automatic bus_start();
        r_sda = 1'b0; cyc(8); r_scl = 1'b0;
    endtask

    task automatic bus_rstart();
        cyc(4); r_sda = 1'b1; cyc(4); r_scl = 1'b1; cyc(4); r_sda = 1'b0; cyc(4); r_scl = 1'b0;
    endtask

    task automatic bus_stop();
        cyc(4); r_sda = 1'b0; cyc(4); r_scl = 1'b1; cyc(4); r_sda = 1'b1; cyc(8);
    endtask

    // Entered and left with SCL low; line and sda_oe sampled mid-way through SCL high.
    task automatic bus_bit(input logic b, output logic line, output logic oe);
        cyc(4); r_sda = b; cyc(4); r_scl = 1'b1; cyc(4);
        line = w_sda_line; oe = sda_oe;
        cyc(4); r_scl = 1'b0;
    endtask

    task automatic bus_byte(input logic [7:0] b, output logic an, output logic aoe);
        logic l, o;
        for (int i = 7; i >= 0; i--) bus_bit(b[i], l, o);
        bus_bit(1'b1, an, aoe);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clr_mon();
        cyc(3);
        check_val("rst_oe",    sda_oe,    0);
        check_val("rst_data",  rx_data,   8'h00);
        check_val("rst_valid", rx_valid,  0);
        check_val("rst_hit",   addr_hit,  0);
        check_val("rst_busy",  busy,      0);
        check_val("rst_start", start_det, 0);
        check_val("rst_stop",  stop_det,  0);
        r_rst = 1'b1;
        cyc(4);

        // Basic write 0x54, 0xA5 with START latency check
        clr_mon();
        r_sda = 1'b0; cyc(2);
        check_val("s1_start_early", start_det, 0);
        cyc(1);
        check_val("s1_start_lat", start_det, 1);
        cyc(5); r_scl = 1'b0;
        check_val("s1_busy", busy, 1);
        bus_byte(8'h54, ack_n, ack_oe);
        check_val("s1_addr_ack", ack_n, 0);
        check_val("s1_addr_oe", ack_oe, 1);
        bus_byte(8'hA5, ack_n, ack_oe);
        check_val("s1_data_ack", ack_n, 0);
        check_val("s1_data_oe", ack_oe, 1);
        check_val("s1_hit", addr_hit, 1);
        bus_stop();
        check_val("s1_rx_cnt", rx_cnt, 1);
        check_val("s1_rxq0", (rxq.size() > 0) ? rxq[0] : 8'hxx, 8'hA5);
        check_val("s1_rx_data", rx_data, 8'hA5);
        check_val("s1_st_cnt", st_cnt, 1);
        check_val("s1_sp_cnt", sp_cnt, 1);
        check_val("s1_busy_end", busy, 0);
        check_val("s1_hit_end", addr_hit, 0);

        // Wrong address 0x2B
        clr_mon();
        bus_start();
        bus_byte(8'h56, ack_n, ack_oe);
        check_val("s2_nack", ack_n, 1);
        bus_byte(8'h11, ack_n, ack_oe);
        bus_stop();
        check_val("s2_oe_seen", oe_seen, 0);
        check_val("s2_rx_cnt", rx_cnt, 0);
        check_val("s2_hit_seen", hit_seen, 0);

        // Matching address, read bit
        clr_mon();
        bus_start();
        bus_byte(8'h55, ack_n, ack_oe);
        check_val("s3_nack", ack_n, 1);
        check_val("s3_state", dut.r_state, IGNORE);
        bus_byte(8'h33, ack_n, ack_oe);
        check_val("s3_state2", dut.r_state, IGNORE);
        bus_stop();
        check_val("s3_rx_cnt", rx_cnt, 0);
        check_val("s3_oe_seen", oe_seen, 0);

        // Repeated START
        clr_mon();
        bus_start();
        bus_byte(8'h54, ack_n, ack_oe);
        bus_byte(8'h01, ack_n, ack_oe);
        check_val("s4_hit1", addr_hit, 1);
        bus_rstart();
        check_val("s4_hit_drop", addr_hit, 0);
        check_val("s4_busy", busy, 1);
        bus_byte(8'h54, ack_n, ack_oe);
        check_val("s4_addr2_ack", ack_n, 0);
        bus_byte(8'h02, ack_n, ack_oe);
        check_val("s4_hit2", addr_hit, 1);
        bus_stop();
        check_val("s4_rx_cnt", rx_cnt, 2);
        check_val("s4_rxq0", (rxq.size() > 0) ? rxq[0] : 8'hxx, 8'h01);
        check_val("s4_rxq1", (rxq.size() > 1) ? rxq[1] : 8'hxx, 8'h02);
        check_val("s4_st_cnt", st_cnt, 2);
        check_val("s4_sp_cnt", sp_cnt, 1);

        // STOP after a partial data byte
        clr_mon();
        bus_start();
        bus_byte(8'h54, ack_n, ack_oe);
        bus_bit(1'b1, l_dummy, o_dummy);
        bus_bit(1'b0, l_dummy, o_dummy);
        bus_bit(1'b1, l_dummy, o_dummy);
        bus_bit(1'b0, l_dummy, o_dummy);
        bus_stop();
        check_val("s5_rx_cnt", rx_cnt, 0);
        check_val("s5_rx_data", rx_data, 8'h02);
        check_val("s5_oe", sda_oe, 0);
        check_val("s5_state", dut.r_state, IDLE);
        clr_mon();
        bus_start();
        bus_byte(8'h54, ack_n, ack_oe);
        bus_byte(8'h7E, ack_n, ack_oe);
        bus_stop();
        check_val("s5_rx_cnt2", rx_cnt, 1);
        check_val("s5_rx_data2", rx_data, 8'h7E);

        // Reset asserted during the data ACK
        clr_mon();
        bus_start();
        bus_byte(8'h54, ack_n, ack_oe);
        for (int i = 7; i >= 0; i--) bus_bit(i[0], l_dummy, o_dummy);
        cyc(5);
        check_val("s6_oe_pre", sda_oe, 1);
        check_val("s6_state_pre", dut.r_state, DATA_ACK);
        #2 r_rst = 1'b0;
        #1;
        check_val("s6_oe", sda_oe, 0);
        check_val("s6_data", rx_data, 8'h00);
        check_val("s6_valid", rx_valid, 0);
        check_val("s6_hit", addr_hit, 0);
        check_val("s6_busy", busy, 0);
        check_val("s6_start", start_det, 0);
        check_val("s6_stop", stop_det, 0);
        cyc(1);
        r_scl = 1'b1; r_sda = 1'b1;
        cyc(4);
        r_rst = 1'b1;
        cyc(4);
        clr_mon();
        bus_start();
        bus_byte(8'h54, ack_n, ack_oe);
        check_val("s6_addr_ack", ack_n, 0);
        bus_byte(8'hC3, ack_n, ack_oe);
        bus_stop();
        check_val("s6_rx_cnt", rx_cnt, 1);
        check_val("s6_rx_data", rx_data, 8'hC3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
